// File: rtl/fmac_fifo_wr_arb_if.sv
// Write-side bundle between the two frame sources, the MAC FIFO write port and the arbiter.
// The master side drives requests and FIFO status; the slave side is the arbiter.
`timescale 1ns/1ps
interface fmac_fifo_wr_arb_if #(
   parameter int WIDTH = 8,
   parameter int PTR   = 12
);
   logic             req0, req1;
   logic [PTR:0]     len0, len1;
   logic [WIDTH-1:0] data0, data1;
   logic             valid0, valid1;
   logic             rdy0, rdy1;
   logic             gnt0, gnt1;
   logic             done0, done1;
   logic             err0, err1;
   logic             fifo_wrreq;
   logic [WIDTH-1:0] fifo_data;
   logic [PTR:0]     fifo_wrusedw;
   logic             fifo_wrfull;
   logic             busy;
   logic             owner;

   modport master (
      output req0, req1, len0, len1, data0, data1, valid0, valid1,
      output fifo_wrusedw, fifo_wrfull,
      input  rdy0, rdy1, gnt0, gnt1, done0, done1, err0, err1,
      input  fifo_wrreq, fifo_data, busy, owner
   );

   modport slave (
      input  req0, req1, len0, len1, data0, data1, valid0, valid1,
      input  fifo_wrusedw, fifo_wrfull,
      output rdy0, rdy1, gnt0, gnt1, done0, done1, err0, err1,
      output fifo_wrreq, fifo_data, busy, owner
   );
endinterface

// File: rtl/fmac_fifo_wr_arb.sv
// Packet-granular round-robin arbiter for the MAC FIFO write port: a requester is granted
// only when the FIFO can hold its whole packet, then its bytes are steered in until len expires.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_IDLE   | pick a requester; grant, reject (bad len) or wait for space
// ST_XFER   | owner's bytes flow into the FIFO, cnt counts down to the last byte
// ST_SETTLE | idle gap so fifo_wrusedw catches up before the next decision
`timescale 1ns/1ps
module fmac_fifo_wr_arb #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4096,
   parameter int PTR    = 12,
   parameter int SETTLE = 2
) (
   input  logic               clk,
   input  logic               reset_,
   fmac_fifo_wr_arb_if.slave  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_XFER   = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;

   localparam logic [PTR:0] DEPTH_V  = (PTR+1)'(DEPTH);
   localparam logic [PTR:0] ONE_V    = (PTR+1)'(1);
   localparam logic [2:0]   SETTLE_V = 3'(SETTLE);

   logic [1:0]       state;
   logic [PTR:0]     cnt;
   logic [2:0]       settle_cnt;
   logic             last_owner;
   logic             owner_q;
   logic [WIDTH-1:0] data_q;
   logic [1:0]       gnt_q, done_q, err_q;

   logic             sel_any, sel;
   logic [PTR:0]     sel_len, space;
   logic             len_bad, fits;
   logic             rdy_own, valid_own, wr;
   logic [WIDTH-1:0] data_own;

   // On a tie the requester that did not go last wins.
   always_comb begin
      sel_any = bus.req0 | bus.req1;
      sel     = (bus.req0 & bus.req1) ? ~last_owner : bus.req1;
      sel_len = sel ? bus.len1 : bus.len0;
      len_bad = (sel_len == '0) || (sel_len > DEPTH_V);
      space   = DEPTH_V - bus.fifo_wrusedw;
      fits    = (space >= sel_len);
   end

   assign rdy_own   = (state == ST_XFER) & ~bus.fifo_wrfull;
   assign valid_own = owner_q ? bus.valid1 : bus.valid0;
   assign data_own  = owner_q ? bus.data1  : bus.data0;
   assign wr        = rdy_own & valid_own;

   assign bus.rdy0       = rdy_own & ~owner_q;
   assign bus.rdy1       = rdy_own &  owner_q;
   assign bus.fifo_wrreq = wr;
   assign bus.fifo_data  = wr ? data_own : data_q;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.owner      = owner_q;
   assign bus.gnt0       = gnt_q[0];
   assign bus.gnt1       = gnt_q[1];
   assign bus.done0      = done_q[0];
   assign bus.done1      = done_q[1];
   assign bus.err0       = err_q[0];
   assign bus.err1       = err_q[1];

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         settle_cnt <= '0;
         last_owner <= 1'b1;
         owner_q    <= 1'b0;
         data_q     <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         err_q  <= '0;
         if (wr) data_q <= data_own;
         case (state)
            ST_IDLE: begin
               if (sel_any) begin
                  if (len_bad) begin
                     err_q      <= sel ? 2'b10 : 2'b01;
                     last_owner <= sel;
                     settle_cnt <= SETTLE_V;
                     state      <= ST_SETTLE;
                  end else if (fits) begin
                     gnt_q      <= sel ? 2'b10 : 2'b01;
                     cnt        <= sel_len;
                     owner_q    <= sel;
                     last_owner <= sel;
                     state      <= ST_XFER;
                  end
               end
            end
            ST_XFER: begin
               if (wr) begin
                  cnt <= cnt - ONE_V;
                  if (cnt == ONE_V) begin
                     done_q     <= owner_q ? 2'b10 : 2'b01;
                     settle_cnt <= SETTLE_V;
                     state      <= ST_SETTLE;
                  end
               end
            end
            ST_SETTLE: begin
               settle_cnt <= settle_cnt - 3'd1;
               if (settle_cnt <= 3'd1) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fmac_fifo_wr_arb.sv
// Directed bench for fmac_fifo_wr_arb: inputs change on the falling edge, outputs are
// sampled 1 ns later, so every check sees the state left by the preceding rising edge.
`timescale 1ns/1ps
module tb_fmac_fifo_wr_arb;
   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4096;
   localparam int PTR    = 12;
   localparam int SETTLE = 2;

   logic clk = 1'b0;
   logic reset_;
   int   checks = 0;
   int   errors = 0;

   fmac_fifo_wr_arb_if #(.WIDTH(WIDTH), .PTR(PTR)) bus ();

   fmac_fifo_wr_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .SETTLE(SETTLE)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic clear_inputs();
      bus.req0 = 0; bus.req1 = 0; bus.len0 = '0; bus.len1 = '0;
      bus.data0 = '0; bus.data1 = '0; bus.valid0 = 0; bus.valid1 = 0;
      bus.fifo_wrusedw = '0; bus.fifo_wrfull = 0;
   endtask

   // Leaves the bench exactly on a falling edge with reset released and inputs idle.
   task automatic do_reset();
      reset_ = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset_ = 1'b1;
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      clear_inputs();
      bus.valid0 = 1; bus.valid1 = 1; bus.data0 = 8'hEE;
      #3;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.rdy0, bus.rdy1,
           bus.fifo_wrreq, bus.busy, bus.owner} !== 11'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 0", {bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                  bus.err0, bus.err1, bus.rdy0, bus.rdy1, bus.fifo_wrreq, bus.busy, bus.owner});
      end
      checks++;
      if (bus.fifo_data !== 8'h00) begin
         errors++; $display("FAIL reset_fifo_data got %h exp 00", bus.fifo_data);
      end
      @(negedge clk);
      reset_ = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.rdy0, bus.fifo_wrreq, bus.owner} !== 4'b0000) begin
         errors++; $display("FAIL reset_release got %b exp 0000", {bus.busy, bus.rdy0, bus.fifo_wrreq, bus.owner});
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req0 = 1; bus.len0 = 13'd3;
      #1;
      checks++;
      if ({bus.gnt0, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL single_idle got %b exp 00", {bus.gnt0, bus.busy});
      end
      @(negedge clk);
      bus.req0 = 0; bus.valid0 = 1; bus.data0 = 8'hA1;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.owner, bus.rdy0, bus.rdy1, bus.fifo_wrreq} !== 7'b1010101) begin
         errors++; $display("FAIL single_gnt got %b exp 1010101",
                            {bus.gnt0, bus.gnt1, bus.busy, bus.owner, bus.rdy0, bus.rdy1, bus.fifo_wrreq});
      end
      checks++;
      if (bus.fifo_data !== 8'hA1) begin
         errors++; $display("FAIL single_a1 got %h exp a1", bus.fifo_data);
      end
      @(negedge clk);
      bus.data0 = 8'hA2;
      #1;
      checks++;
      if ({bus.gnt0, bus.fifo_wrreq} !== 2'b01 || bus.fifo_data !== 8'hA2) begin
         errors++; $display("FAIL single_a2 got %b/%h exp 01/a2", {bus.gnt0, bus.fifo_wrreq}, bus.fifo_data);
      end
      @(negedge clk);
      bus.data0 = 8'hA3;
      #1;
      checks++;
      if (bus.fifo_wrreq !== 1'b1 || bus.fifo_data !== 8'hA3) begin
         errors++; $display("FAIL single_a3 got %b/%h exp 1/a3", bus.fifo_wrreq, bus.fifo_data);
      end
      @(negedge clk);
      bus.valid0 = 0; bus.data0 = 8'h55;
      #1;
      checks++;
      if ({bus.done0, bus.busy, bus.fifo_wrreq, bus.rdy0} !== 4'b1100) begin
         errors++; $display("FAIL single_done got %b exp 1100", {bus.done0, bus.busy, bus.fifo_wrreq, bus.rdy0});
      end
      checks++;
      if (bus.fifo_data !== 8'hA3) begin
         errors++; $display("FAIL single_data_hold got %h exp a3", bus.fifo_data);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.done0, bus.busy} !== 2'b01) begin
         errors++; $display("FAIL single_settle got %b exp 01", {bus.done0, bus.busy});
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL single_idle_again got %b exp 0", bus.busy);
      end
   endtask

   task automatic test_tie();
      do_reset();
      bus.req0 = 1; bus.req1 = 1; bus.len0 = 13'd2; bus.len1 = 13'd2;
      bus.valid0 = 1; bus.data0 = 8'h10; bus.valid1 = 1; bus.data1 = 8'h20;
      #1;
      checks++;
      if ({bus.rdy0, bus.rdy1, bus.fifo_wrreq, bus.busy} !== 4'b0000) begin
         errors++; $display("FAIL tie_idle_quiet got %b exp 0000", {bus.rdy0, bus.rdy1, bus.fifo_wrreq, bus.busy});
      end
      @(negedge clk);
      bus.req0 = 0;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.owner, bus.rdy1, bus.fifo_wrreq} !== 5'b10001 || bus.fifo_data !== 8'h10) begin
         errors++; $display("FAIL tie_first_gnt0 got %b/%h exp 10001/10",
                            {bus.gnt0, bus.gnt1, bus.owner, bus.rdy1, bus.fifo_wrreq}, bus.fifo_data);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.done0, bus.done1} !== 2'b10) begin
         errors++; $display("FAIL tie_done0 got %b exp 10", {bus.done0, bus.done1});
      end
      repeat (3) @(negedge clk);
      bus.req1 = 0;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.owner, bus.rdy0, bus.rdy1, bus.fifo_wrreq} !== 6'b011011 || bus.fifo_data !== 8'h20) begin
         errors++; $display("FAIL tie_second_gnt1 got %b/%h exp 011011/20",
                            {bus.gnt0, bus.gnt1, bus.owner, bus.rdy0, bus.rdy1, bus.fifo_wrreq}, bus.fifo_data);
      end
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({bus.done0, bus.done1} !== 2'b01) begin
         errors++; $display("FAIL tie_done1 got %b exp 01", {bus.done0, bus.done1});
      end
      repeat (2) @(negedge clk);
      bus.req0 = 1; bus.req1 = 1;
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL tie_idle_before_rerequest got %b exp 0", bus.busy);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.owner} !== 3'b100) begin
         errors++; $display("FAIL tie_rr_gnt0 got %b exp 100", {bus.gnt0, bus.gnt1, bus.owner});
      end
      bus.req0 = 0; bus.req1 = 0;
      repeat (6) @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_space();
      int writes;
      do_reset();
      bus.fifo_wrusedw = 13'd4000; bus.req1 = 1; bus.len1 = 13'd100;
      repeat (4) begin
         @(negedge clk);
         #1;
         checks++;
         if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b000) begin
            errors++; $display("FAIL space_blocked got %b exp 000", {bus.gnt0, bus.gnt1, bus.busy});
         end
      end
      bus.fifo_wrusedw = 13'd3996;
      @(negedge clk);
      #1;
      checks++;
      if ({bus.gnt1, bus.busy, bus.owner} !== 3'b111) begin
         errors++; $display("FAIL space_exact_fit got %b exp 111", {bus.gnt1, bus.busy, bus.owner});
      end
      bus.req1 = 0; bus.valid1 = 1; bus.data1 = 8'h33;
      #1;
      writes = 0;
      for (int k = 0; k < 130 && bus.done1 !== 1'b1; k++) begin
         if (bus.fifo_wrreq === 1'b1) writes++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (bus.done1 !== 1'b1 || writes != 100) begin
         errors++; $display("FAIL space_len100_writes got done=%b writes=%0d exp done=1 writes=100", bus.done1, writes);
      end
      bus.valid1 = 0;
      repeat (3) @(negedge clk);

      do_reset();
      bus.fifo_wrusedw = 13'd1; bus.req1 = 1; bus.len1 = 13'd4096;
      @(negedge clk);
      #1;
      checks++;
      if ({bus.gnt1, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL space_full_len_blocked got %b exp 00", {bus.gnt1, bus.busy});
      end
      bus.fifo_wrusedw = 13'd0;
      @(negedge clk);
      #1;
      checks++;
      if ({bus.gnt1, bus.busy, bus.err1} !== 3'b110) begin
         errors++; $display("FAIL space_full_len_gnt got %b exp 110", {bus.gnt1, bus.busy, bus.err1});
      end
   endtask

   task automatic test_illegal();
      logic [PTR:0] bad_len [2];
      bad_len[0] = 13'd0;
      bad_len[1] = 13'd5000;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         bus.req0 = 1; bus.len0 = bad_len[k]; bus.valid0 = 1;
         @(negedge clk);
         bus.req0 = 0;
         #1;
         checks++;
         if ({bus.err0, bus.err1, bus.gnt0, bus.busy, bus.fifo_wrreq, bus.rdy0} !== 6'b100100) begin
            errors++; $display("FAIL illegal_err len=%0d got %b exp 100100", bad_len[k],
                               {bus.err0, bus.err1, bus.gnt0, bus.busy, bus.fifo_wrreq, bus.rdy0});
         end
         @(negedge clk);
         #1;
         checks++;
         if ({bus.err0, bus.busy, bus.fifo_wrreq} !== 3'b010) begin
            errors++; $display("FAIL illegal_settle len=%0d got %b exp 010", bad_len[k], {bus.err0, bus.busy, bus.fifo_wrreq});
         end
         @(negedge clk);
         #1;
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL illegal_idle len=%0d got %b exp 0", bad_len[k], bus.busy);
         end
      end
   endtask

   task automatic test_stall();
      logic vv [7];
      logic ff [7];
      logic ww [7];
      int   writes;
      vv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      ff = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      ww = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      writes = 0;
      do_reset();
      bus.req0 = 1; bus.len0 = 13'd4;
      @(negedge clk);
      bus.req0 = 0;
      for (int k = 0; k < 7; k++) begin
         bus.valid0 = vv[k]; bus.fifo_wrfull = ff[k]; bus.data0 = 8'hC0 + 8'(k);
         #1;
         checks++;
         if (bus.fifo_wrreq !== ww[k] || bus.rdy0 !== ~ff[k]) begin
            errors++; $display("FAIL stall_cycle%0d got wrreq=%b rdy0=%b exp wrreq=%b rdy0=%b",
                               k, bus.fifo_wrreq, bus.rdy0, ww[k], ~ff[k]);
         end
         if (bus.fifo_wrreq === 1'b1) begin
            writes++;
            checks++;
            if (bus.fifo_data !== 8'hC0 + 8'(k)) begin
               errors++; $display("FAIL stall_data%0d got %h exp %h", k, bus.fifo_data, 8'hC0 + 8'(k));
            end
         end
         @(negedge clk);
      end
      bus.valid0 = 1; bus.fifo_wrfull = 0;
      #1;
      checks++;
      if ({bus.done0, bus.fifo_wrreq, bus.busy} !== 3'b101 || writes != 4) begin
         errors++; $display("FAIL stall_done got %b writes=%0d exp 101 writes=4",
                            {bus.done0, bus.fifo_wrreq, bus.busy}, writes);
      end
      bus.valid0 = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int writes;
      writes = 0;
      do_reset();
      bus.req0 = 1; bus.len0 = 13'd10;
      @(negedge clk);
      bus.req0 = 0; bus.valid0 = 1; bus.data0 = 8'h77;
      repeat (5) begin
         #1;
         if (bus.fifo_wrreq === 1'b1) writes++;
         @(negedge clk);
      end
      #2;
      reset_ = 1'b0;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.rdy0, bus.rdy1,
           bus.fifo_wrreq, bus.busy, bus.owner} !== 11'b0 || bus.fifo_data !== 8'h00 || writes != 5) begin
         errors++; $display("FAIL reset_mid_abort got %b/%h writes=%0d exp 0/00 writes=5",
                            {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1, bus.rdy0, bus.rdy1,
                             bus.fifo_wrreq, bus.busy, bus.owner}, bus.fifo_data, writes);
      end
      clear_inputs();
      @(negedge clk);
      reset_ = 1'b1;
      bus.req1 = 1; bus.len1 = 13'd4;
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_idle got %b exp 0", bus.busy);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus.gnt1, bus.owner, bus.busy} !== 3'b111) begin
         errors++; $display("FAIL reset_mid_regrant got %b exp 111", {bus.gnt1, bus.owner, bus.busy});
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_space();
      test_illegal();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
